// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one cipher round per clock with on-the-fly key expansion.
// Optional macro AES_BLOCK_COUNT_EN adds blk_count, a 32-bit count of delivered ciphertexts.

module aes128_round_sequencer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
`ifdef AES_BLOCK_COUNT_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] rk_next;
  logic [127:0] sub_shift_out;
  logic [127:0] mix_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Inverse computed as x^254 (so 0 maps to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = gf_mul(x, x);
    inv = p;
    for (int i = 0; i < 6; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte k sits at [127-8k -: 8]; row r of column c is byte 4c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int           src;
    int           dst;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        dst = 4 * c + r;
        src = 4 * ((c + r) % 4) + r;
        o[127 - 8 * dst -: 8] = sbox(s[127 - 8 * src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]),  mix_column(s[31:0])};
  endfunction

  function automatic logic [7:0] rcon_byte(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    rk_next       = expand_key(rk_q, rcon_byte(rnd_q));
    sub_shift_out = sub_shift(state_q);
    mix_out       = mix_columns(sub_shift_out);
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rk_d      = rk_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_block ^ in_key;
          rk_d    = in_key;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        rk_d = rk_next;
        // The final round skips MixColumns.
        if (rnd_q == 4'd10) begin
          state_d = sub_shift_out ^ rk_next;
          rnd_d   = 4'd0;
          fsm_d   = DONE;
        end else begin
          state_d = mix_out ^ rk_next;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign out_block = (fsm_q == DONE) ? state_q : 128'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
    end
  end

`ifdef AES_BLOCK_COUNT_EN
  logic [31:0] blk_count_q, blk_count_d;

  always_comb begin
    blk_count_d = blk_count_q;
    if (out_valid && out_ready) blk_count_d = blk_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_count_q <= '0;
    else        blk_count_q <= blk_count_d;
  end

  assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Self-checking bench for aes128_round_sequencer: known-answer vectors, random blocks and a
// table-driven AES reference model; handshakes are scoreboarded on the falling edge.

module tb_aes128_round_sequencer;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_block = '0;
  logic [127:0] in_key = '0;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_block;
  logic         busy;
`ifdef AES_BLOCK_COUNT_EN
  logic [31:0]  blk_count;
`endif

  aes128_round_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
`ifdef AES_BLOCK_COUNT_EN
    ,
    .blk_count (blk_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  int last_acc_cyc = -1;
  int last_out_cyc = -1;
  logic [127:0] exp_q[$];
  int           acc_cyc[$];

  logic [7:0] sb[256];
  logic [7:0] ex[256];
  int         lg[256];

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Log/antilog tables over generator 3; the S-box comes from table inversion plus the affine map.
  task automatic build_tables();
    logic [7:0] e;
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] c8;
    c8 = 8'h63;
    e  = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = e;
      lg[e] = i;
      e = e ^ xt(e);
    end
    ex[255] = ex[0];
    lg[0]   = 0;
    for (int x = 0; x < 256; x++) begin
      b = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c8[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return ex[(lg[a] + lg[b]) % 255];
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w[44];
    logic [7:0]   st[4][4];
    logic [7:0]   tmp[4][4];
    logic [7:0]   rc;
    logic [31:0]  t;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = pt[127 - 8 * (4 * c + r) -: 8] ^ w[c][31 - 8 * r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          tmp[r][c] = sb[st[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++) begin
        a0 = tmp[0][c]; a1 = tmp[1][c]; a2 = tmp[2][c]; a3 = tmp[3][c];
        if (rd < 10) begin
          st[0][c] = gm(a0, 8'd2) ^ gm(a1, 8'd3) ^ a2 ^ a3;
          st[1][c] = a0 ^ gm(a1, 8'd2) ^ gm(a2, 8'd3) ^ a3;
          st[2][c] = a0 ^ a1 ^ gm(a2, 8'd2) ^ gm(a3, 8'd3);
          st[3][c] = gm(a0, 8'd3) ^ a1 ^ a2 ^ gm(a3, 8'd2);
        end else begin
          st[0][c] = a0; st[1][c] = a1; st[2][c] = a2; st[3][c] = a3;
        end
        for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ w[4 * rd + c][31 - 8 * r -: 8];
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8 * (4 * c + r) -: 8] = st[r][c];
    return res;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are observed mid-cycle, so they describe the edge that follows.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("excl", {127'd0, out_valid & in_ready}, 128'd0);
      checkOutput("busy", {127'd0, busy}, {127'd0, ~in_ready});
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_encrypt(in_key, in_block));
        acc_cyc.push_back(cyc);
        n_acc++;
        last_acc_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        n_out++;
        last_out_cyc = cyc;
        if (exp_q.size() == 0) checkOutput("spurious", 128'd1, 128'd0);
        else                   checkOutput("ct", out_block, exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt);
    int n;
    n        = 0;
    in_key   = key;
    in_block = pt;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput("accept", {127'd0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic drain(input bit random_bp);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      out_ready = random_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b0;
    checkOutput("drain", 128'(exp_q.size()), 128'd0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int lat;
    int base;
    int d1;
    int d2;
    build_tables();

    // Reset values, both while asserted and just after release.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {127'd0, in_ready}, 128'd1);
    checkOutput("rst_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("rst_out_block", out_block, 128'd0);
    checkOutput("rst_busy", {127'd0, busy}, 128'd0);
`ifdef AES_BLOCK_COUNT_EN
    checkOutput("rst_count", 128'(blk_count), 128'd0);
`endif
    rst_n = 1'b1;
    tick();
    checkOutput("rel_in_ready", {127'd0, in_ready}, 128'd1);

    // FIPS-197 C.1 with exact latency, then App. B.
    applyStimulus(C1_KEY, C1_PT);
    wait_valid(lat);
    checkOutput("c1_latency", 128'(lat), 128'd10);
    checkOutput("c1_kat", out_block, C1_CT);
    drain(1'b0);
    applyStimulus(B_KEY, B_PT);
    wait_valid(lat);
    checkOutput("b_kat", out_block, B_CT);
    drain(1'b0);

    // Zero vector under long backpressure; a waiting block must not slip in early.
    applyStimulus(128'd0, 128'd0);
    wait_valid(lat);
    checkOutput("z_valid", {127'd0, out_valid}, 128'd1);
    in_key   = C1_KEY;
    in_block = C1_PT;
    in_valid = 1'b1;
    base     = n_acc;
    for (int i = 0; i < 20; i++) begin
      checkOutput("z_hold", out_block, Z_CT);
      checkOutput("z_in_ready", {127'd0, in_ready}, 128'd0);
      tick();
    end
    checkOutput("z_no_accept", 128'(n_acc - base), 128'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("z_cleared", {127'd0, out_valid}, 128'd0);
    tick();
    in_valid = 1'b0;
    checkOutput("z_accept_gap", 128'(last_acc_cyc - last_out_cyc), 128'd1);
    wait_valid(lat);
    drain(1'b0);

    // Inputs changing after the accept edge must not disturb the block in flight.
    applyStimulus(rand128(), rand128());
    for (int i = 0; i < 5; i++) begin
      in_key   = rand128();
      in_block = rand128();
      tick();
    end
    wait_valid(lat);
    drain(1'b0);

    // Random blocks with random backpressure and idle gaps.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(rand128(), rand128());
      drain(1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset in round 5: block is dropped, nothing emerges, then a fresh block works.
    applyStimulus(C1_KEY, C1_PT);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    checkOutput("mid_rst_busy", {127'd0, busy}, 128'd0);
    checkOutput("mid_rst_block", out_block, 128'd0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    checkOutput("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      checkOutput("mid_rst_no_out", {127'd0, out_valid}, 128'd0);
      tick();
    end
    out_ready = 1'b0;
    applyStimulus(C1_KEY, C1_PT);
    wait_valid(lat);
    checkOutput("post_rst_latency", 128'(lat), 128'd10);
    checkOutput("post_rst_kat", out_block, C1_CT);
    drain(1'b0);

    // Back-to-back C.1 blocks with both sides always ready.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    acc_cyc.delete();
    base      = n_out;
    in_key    = C1_KEY;
    in_block  = C1_PT;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    lat = 0;
    while (acc_cyc.size() < 3 && lat < 100) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    checkOutput("b2b_accepts", 128'(acc_cyc.size()), 128'd3);
    d1 = (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1;
    d2 = (acc_cyc.size() >= 3) ? acc_cyc[2] - acc_cyc[1] : -1;
    checkOutput("b2b_gap1", 128'(d1), 128'd12);
    checkOutput("b2b_gap2", 128'(d2), 128'd12);
    drain(1'b0);
    checkOutput("b2b_outputs", 128'(n_out - base), 128'd3);
`ifdef AES_BLOCK_COUNT_EN
    checkOutput("b2b_count", 128'(blk_count), 128'd3);
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
